// File: rtl/conv_controller.sv
// Frame controller for a sliding-window convolution datapath.
// Optional stall counter enabled by CONV_CTRL_STALL_COUNT_EN.
module conv_controller #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 5,
  parameter int IMAGE_SIZE   = 28,
  parameter int PIPE_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pixel_in_valid,
  output logic                  pixel_in_ready,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  output logic [DATA_WIDTH-1:0] pixel_input,
  output logic                  write,
  input  logic [DATA_WIDTH-1:0] add_result,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  busy,
`ifdef CONV_CTRL_STALL_COUNT_EN
  output logic                  done,
  output logic [15:0]           stall_count
`else
  output logic                  done
`endif
);

  localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int DW = (PIPE_LATENCY > 0) ? $clog2(PIPE_LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMAGE_SIZE - 1);
  localparam logic [CW-1:0] KM1  = CW'(KERNEL_SIZE - 1);
  localparam logic [DW-1:0] DEND = DW'(PIPE_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t                  state;
  logic [CW-1:0]           row;
  logic [CW-1:0]           col;
  logic [DW-1:0]           dcnt;
  logic [PIPE_LATENCY-1:0] tags;
  logic                    hs;
  logic                    win;

  assign hs          = pixel_in_valid & pixel_in_ready;
  assign write       = hs;
  assign pixel_input = pixel_in;
  assign win         = hs && (row >= KM1) && (col >= KM1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      row            <= '0;
      col            <= '0;
      dcnt           <= '0;
      pixel_in_ready <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state          <= STREAM;
            row            <= '0;
            col            <= '0;
            pixel_in_ready <= 1'b1;
            busy           <= 1'b1;
          end
        end
        STREAM: begin
          if (hs) begin
            if (col == LAST) begin
              col <= '0;
              if (row == LAST) begin
                // last pixel of the frame: stop accepting
                row            <= '0;
                state          <= DRAIN;
                dcnt           <= '0;
                pixel_in_ready <= 1'b0;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (dcnt == DEND) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // tag tracks which datapath sums are real window outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tags         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      tags         <= (tags << 1) | PIPE_LATENCY'(win);
      result_valid <= tags[PIPE_LATENCY-1];
      if (tags[PIPE_LATENCY-1]) begin
        result <= add_result;
      end
    end
  end

`ifdef CONV_CTRL_STALL_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (state == IDLE && start) begin
      stall_count <= '0;
    end else if (state == STREAM && !pixel_in_valid
                 && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_controller.sv
// Scoreboard bench for conv_controller.
// Reference model runs on the falling edge.
module tb_conv_controller;
  localparam int DW = 16;
  localparam int K  = 5;
  localparam int N  = 28;
  localparam int PL = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          pixel_in_valid;
  logic          pixel_in_ready;
  logic [DW-1:0] pixel_in;
  logic [DW-1:0] pixel_input;
  logic          write;
  logic [DW-1:0] add_result;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          busy;
  logic          done;
`ifdef CONV_CTRL_STALL_COUNT_EN
  logic [15:0]   stall_count;
`endif

  conv_controller #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (K),
    .IMAGE_SIZE  (N),
    .PIPE_LATENCY(PL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pixel_in_valid(pixel_in_valid),
    .pixel_in_ready(pixel_in_ready),
    .pixel_in      (pixel_in),
    .pixel_input   (pixel_input),
    .write         (write),
    .add_result    (add_result),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy),
`ifdef CONV_CTRL_STALL_COUNT_EN
    .done          (done),
    .stall_count   (stall_count)
`else
    .done          (done)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit const_mode = 1'b0;

  function automatic logic [DW-1:0] fexp(input int c);
    return const_mode ? 16'h0180 : DW'(c * 37 + 11);
  endfunction

  always @(posedge clk) begin
    #1;
    add_result = fexp(cyc);
  end

  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   m_st, m_row, m_col, m_dcnt, m_stall;
  int   n_res, n_hs, last_hs, done_cyc, first_win, first_rv;
  bit   frame_over;
  bit   m_hs;

  task automatic clear_frame();
    q.delete();
    n_res     = 0;
    n_hs      = 0;
    last_hs   = -1;
    done_cyc  = -1;
    first_win = -1;
    first_rv  = -1;
    frame_over = 1'b0;
  endtask

  task automatic clear_model();
    m_st    = 0;
    m_row   = 0;
    m_col   = 0;
    m_dcnt  = 0;
    m_stall = 0;
    clear_frame();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      m_hs = (m_st == 1) && (pixel_in_valid === 1'b1);
      checks++;
      if (pixel_in_ready !== (m_st == 1)) begin
        errors++;
        $display("FAIL ready cyc=%0d got %b want %b",
                 cyc, pixel_in_ready, m_st == 1);
      end
      checks++;
      if (write !== m_hs) begin
        errors++;
        $display("FAIL write cyc=%0d got %b want %b", cyc, write, m_hs);
      end
      checks++;
      if (busy !== (m_st != 0)) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, m_st != 0);
      end
      checks++;
      if (done !== (m_st == 3)) begin
        errors++;
        $display("FAIL done cyc=%0d got %b want %b", cyc, done, m_st == 3);
      end
      if (m_hs) begin
        checks++;
        if (pixel_input !== pixel_in) begin
          errors++;
          $display("FAIL pixel_input cyc=%0d got %h want %h",
                   cyc, pixel_input, pixel_in);
        end
      end
`ifdef CONV_CTRL_STALL_COUNT_EN
      checks++;
      if (stall_count !== 16'(m_stall)) begin
        errors++;
        $display("FAIL stall_count cyc=%0d got %0d want %0d",
                 cyc, stall_count, m_stall);
      end
`endif
      if (q.size() > 0 && q[0].due == cyc) begin
        checks++;
        if (result_valid !== 1'b1 || result !== q[0].val) begin
          errors++;
          $display("FAIL result cyc=%0d got v=%b %h want v=1 %h",
                   cyc, result_valid, result, q[0].val);
        end
        if (first_rv < 0) first_rv = cyc;
        n_res++;
        void'(q.pop_front());
      end else begin
        checks++;
        if (result_valid !== 1'b0) begin
          errors++;
          $display("FAIL result_valid cyc=%0d got %b want 0",
                   cyc, result_valid);
        end
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      case (m_st)
        0: begin
          if (start === 1'b1) begin
            m_st    = 1;
            m_row   = 0;
            m_col   = 0;
            m_stall = 0;
          end
        end
        1: begin
          if (pixel_in_valid !== 1'b1 && m_stall < 65535) m_stall++;
          if (m_hs) begin
            n_hs++;
            if (m_row >= K - 1 && m_col >= K - 1) begin
              q.push_back('{due: cyc + PL + 1, val: fexp(cyc + PL)});
              if (first_win < 0) first_win = cyc;
            end
            if (m_col == N - 1) begin
              m_col = 0;
              if (m_row == N - 1) begin
                m_row   = 0;
                m_st    = 2;
                m_dcnt  = 0;
                last_hs = cyc;
              end else begin
                m_row++;
              end
            end else begin
              m_col++;
            end
          end
        end
        2: begin
          if (m_dcnt == PL) m_st = 3;
          else m_dcnt++;
        end
        default: begin
          m_st       = 0;
          frame_over = 1'b1;
        end
      endcase
    end
  end

  task automatic run_frame(input int mode);
    clear_frame();
    @(posedge clk); #1;
    start          = 1'b1;
    pixel_in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4000 && !frame_over; k++) begin
      pixel_in_valid = (mode == 1) ? (k % 2 == 0) : 1'b1;
      pixel_in       = DW'($urandom);
      start = (mode == 2) && (k == 10 || k == 400 || k == 800);
      @(posedge clk); #1;
    end
    start          = 1'b0;
    pixel_in_valid = 1'b0;
    checks++;
    if (!frame_over) begin
      errors++;
      $display("FAIL frame_timeout got busy=%b want frame end", busy);
    end
  endtask

  task automatic check_frame(input string tag);
    checks++;
    if (n_res != (N - K + 1) * (N - K + 1)) begin
      errors++;
      $display("FAIL %s result_count got %0d want %0d",
               tag, n_res, (N - K + 1) * (N - K + 1));
    end
    checks++;
    if (done_cyc - last_hs != PL + 2) begin
      errors++;
      $display("FAIL %s done_latency got %0d want %0d",
               tag, done_cyc - last_hs, PL + 2);
    end
    checks++;
    if (first_rv - first_win != PL + 1) begin
      errors++;
      $display("FAIL %s first_result_latency got %0d want %0d",
               tag, first_rv - first_win, PL + 1);
    end
  endtask

  task automatic test_reset();
    mon_en         = 1'b0;
    reset          = 1'b1;
    start          = 1'b1;
    pixel_in_valid = 1'b1;
    pixel_in       = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pixel_in_ready !== 1'b0 || write !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake got ready=%b write=%b want 0 0",
               pixel_in_ready, write);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (result !== '0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_result got %h v=%b want 0 v=0",
               result, result_valid);
    end
    start          = 1'b0;
    pixel_in_valid = 1'b0;
    reset          = 1'b0;
    clear_model();
    mon_en = 1'b1;
  endtask

  task automatic test_full_frame();
    const_mode = 1'b0;
    run_frame(0);
    check_frame("full_frame");
  endtask

  task automatic test_bubbles();
    run_frame(1);
    check_frame("bubbles");
`ifdef CONV_CTRL_STALL_COUNT_EN
    checks++;
    if (stall_count !== 16'd783) begin
      errors++;
      $display("FAIL bubbles_stall got %0d want 783", stall_count);
    end
`endif
  endtask

  task automatic test_const_result();
    const_mode = 1'b1;
    run_frame(0);
    check_frame("const_result");
    checks++;
    if (result !== 16'h0180) begin
      errors++;
      $display("FAIL const_hold got %h want 0180", result);
    end
    const_mode = 1'b0;
  endtask

  task automatic test_start_ignored();
    run_frame(2);
    check_frame("start_ignored");
  endtask

  task automatic test_mid_reset();
    clear_frame();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 1000 && n_hs < 300; k++) begin
      pixel_in_valid = 1'b1;
      pixel_in       = DW'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    mon_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (result !== '0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_result got %h v=%b want 0 v=0",
               result, result_valid);
    end
    checks++;
    if (pixel_in_ready !== 1'b0 || write !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl got r=%b w=%b b=%b d=%b want 0000",
               pixel_in_ready, write, busy, done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || write !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle got v=%b w=%b b=%b d=%b want 0000",
                 result_valid, write, busy, done);
      end
    end
    pixel_in_valid = 1'b0;
    @(posedge clk); #1;
    clear_model();
    mon_en = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    start          = 1'b0;
    pixel_in_valid = 1'b0;
    pixel_in       = '0;
    add_result     = '0;
    test_reset();
    test_full_frame();
    test_bubbles();
    test_const_result();
    test_start_ignored();
    test_mid_reset();
    test_full_frame();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_controller.md
CONV_CONTROLLER -- requirements
Module: conv_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 16, pixel/result word width.
REQ-002 Parameter KERNEL_SIZE, default 5, square kernel edge.
REQ-003 Parameter IMAGE_SIZE, default 28, square image edge.
REQ-004 Parameter PIPE_LATENCY, default 3, clocks from the datapath write strobe to the valid add_result.
REQ-005 Port clk, input, 1, single clock; all state on rising edge.
REQ-006 Port reset, input, 1, asynchronous, active-high.
REQ-007 Port start, input, 1, one-cycle frame start request.
REQ-008 Port pixel_in_valid, input, 1, upstream pixel present.
REQ-009 Port pixel_in_ready, output, 1, controller accepts pixel.
REQ-010 Port pixel_in, input, DATA_WIDTH, raster-order pixel.
REQ-011 Port pixel_input, output, DATA_WIDTH, pixel to datapath.
REQ-012 Port write, output, 1, datapath shift/write strobe.
REQ-013 Port add_result, input, DATA_WIDTH, datapath convolution sum.
REQ-014 Port result, output, DATA_WIDTH, registered output feature.
REQ-015 Port result_valid, output, 1, result qualifier.
REQ-016 Port busy, output, 1, frame in progress.
REQ-017 Port done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-018 States: IDLE, STREAM, DRAIN, DONE.
REQ-019 IDLE->STREAM on start; row and col cleared to 0.
REQ-020 pixel_in_ready is 1 only in STREAM; handshake = pixel_in_valid & pixel_in_ready.
REQ-021 On handshake: write=1, pixel_input=pixel_in (combinational pass-through), col increments; at col=IMAGE_SIZE-1 col wraps to 0 and row increments.
REQ-022 No handshake: write=0, counters hold; bubbles are legal at any point.
REQ-023 Accepted pixel is window-valid when row>=KERNEL_SIZE-1 and col>=KERNEL_SIZE-1 (pre-increment values).
REQ-024 Window-valid tag enters a PIPE_LATENCY-deep shift register that shifts every clock; tag=0 on non-handshake cycles.
REQ-025 Tag at pipe output: result<=add_result, result_valid<=1 next edge; otherwise result_valid<=0, result holds.
REQ-026 Handshake at row=col=IMAGE_SIZE-1 -> DRAIN; pixel_in_ready=0 from next cycle.
REQ-027 DRAIN lasts PIPE_LATENCY+1 clocks, then DONE.
REQ-028 DONE: done=1 one cycle, then IDLE.
REQ-029 busy=1 in STREAM, DRAIN, DONE.
REQ-030 start ignored when not IDLE; start and reset together -> reset wins.
REQ-031 Exactly (IMAGE_SIZE-KERNEL_SIZE+1)^2 result_valid pulses per frame (576 default).
REQ-032 Counter widths = clog2(IMAGE_SIZE); no counter exceeds IMAGE_SIZE-1.

Reset
REQ-033 reset asserted asynchronously forces IDLE, row=col=0, tag pipe cleared, result=0, result_valid=0, write=0, pixel_in_ready=0, busy=0, done=0.
REQ-034 Reset mid-frame discards in-flight tags; no result_valid or done until a new start.

Configuration
REQ-035 Macro CONV_CTRL_STALL_COUNT_EN defined: adds output stall_count, 16 bits, counting STREAM cycles with pixel_in_valid=0, cleared on start and reset, saturating at 16'hFFFF.
REQ-036 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-037 Reset, start, 784 pixels valid every cycle -> 576 result_valid pulses; first 4 clocks after the handshake at row=4,col=4; done 4 clocks after last handshake +1.
REQ-038 pixel_in_valid toggling 1/0 -> write mirrors handshakes, still 576 results, stall_count=783 (macro on).
REQ-039 add_result driven 16'h0180 -> every result=16'h0180 while result_valid=1.
REQ-040 reset asserted after 300 pixels -> outputs zero immediately; no result_valid afterwards without start.
REQ-041 start pulsed during STREAM -> ignored, row/col unaffected, frame completes normally.
REQ-042 Row boundary: handshake at col=27,row=3 -> col=0,row=4 next; no tag for col 0..3 of any row.
